// File: rtl/lcd_bus_sequencer.sv
// lcd_bus_sequencer: Avalon-MM slave that runs timed HD44780 bus cycles behind waitrequest.
// Define LCD_BUSY_POLL_EN to replace fixed post-write delays with busy-flag polling.
module lcd_bus_sequencer #(
  parameter int T_AS        = 3,
  parameter int T_EH        = 25,
  parameter int T_AH        = 2,
  parameter int T_PWRUP     = 750000,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000,
  parameter int POLL_MAX    = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data,
  output logic       lcd_timeout
);
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
  localparam int CW = $clog2(max2(max2(max2(T_AS, T_EH), max2(T_AH, T_PWRUP)),
                                  max2(max2(T_EXEC, T_EXEC_LONG), POLL_MAX))) + 1;
  typedef enum logic [2:0] {PWRUP, IDLE, SETUP, EHIGH, HOLD, DONE, RECOVER} state_t;
  state_t state, next;
  logic [CW-1:0] cnt, load, rec_len;
  logic [7:0] wd_l, wd_n;
  logic rs_l, rw_l, rs_n, rw_n, data_oe, last, acc_n, poll;
`ifdef LCD_BUSY_POLL_EN
  localparam int PW = $clog2(POLL_MAX + 1);
  logic poll_n, busy, to_set;
  logic [PW-1:0] polls, polls_n;
  assign rec_len = CW'(1);
`else
  assign poll = 1'b0;
  assign lcd_timeout = 1'b0;
  // Clear-display and return-home need the long execution time
  assign rec_len = (!rs_l && wd_l != 8'h00 && wd_l < 8'h04) ? CW'(T_EXEC_LONG) : CW'(T_EXEC);
`endif
  assign last = cnt == CW'(1);
  assign acc_n = next inside {SETUP, EHIGH, HOLD};
  assign waitrequest = (read | write) & (state != DONE);
  assign LCD_data = data_oe ? wd_l : 'z;
  assign load = next == PWRUP ? CW'(T_PWRUP) : next == SETUP ? CW'(T_AS) :
                next == EHIGH ? CW'(T_EH) : next == HOLD ? CW'(T_AH) :
                next == RECOVER ? rec_len : CW'(1);
  always_comb begin
    next = state;
    rs_n = rs_l;
    rw_n = rw_l;
    wd_n = wd_l;
`ifdef LCD_BUSY_POLL_EN
    poll_n = poll;
    polls_n = polls;
    to_set = 1'b0;
`endif
    case (state)
      PWRUP: next = last ? IDLE : PWRUP;
      IDLE: if (read | write) begin
        next = SETUP;
        rs_n = address[1];
        rw_n = address[0] & ~write;
        wd_n = writedata;
`ifdef LCD_BUSY_POLL_EN
        poll_n = 1'b0;
        polls_n = '0;
`endif
      end
      SETUP: next = last ? EHIGH : SETUP;
      EHIGH: next = last ? HOLD : EHIGH;
      HOLD: next = !last ? HOLD : poll ? RECOVER : DONE;
      DONE: next = rw_l ? IDLE : RECOVER;
`ifdef LCD_BUSY_POLL_EN
      // First visit always issues a poll; later visits judge the sampled DB7
      RECOVER: if (polls != '0 && !busy) next = IDLE;
      else if (polls == PW'(POLL_MAX)) begin
        next = IDLE;
        to_set = 1'b1;
      end else begin
        next = SETUP;
        rs_n = 1'b0;
        rw_n = 1'b1;
        poll_n = 1'b1;
        polls_n = polls + 1'b1;
      end
`else
      RECOVER: next = last ? IDLE : RECOVER;
`endif
      default: next = PWRUP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PWRUP;
      cnt <= CW'(T_PWRUP);
      rs_l <= 1'b0;
      rw_l <= 1'b1;
      wd_l <= 8'h00;
      LCD_E <= 1'b0;
      LCD_RS <= 1'b0;
      LCD_RW <= 1'b1;
      data_oe <= 1'b0;
      readdata <= 8'h00;
    end else begin
      state <= next;
      cnt <= next != state ? load : cnt - CW'(cnt != '0);
      rs_l <= rs_n;
      rw_l <= rw_n;
      wd_l <= wd_n;
      LCD_E <= next == EHIGH;
      LCD_RS <= acc_n & rs_n;
      LCD_RW <= ~acc_n | rw_n;
      data_oe <= acc_n & ~rw_n;
      if (state == EHIGH && last && rw_l && !poll) readdata <= LCD_data;
    end
  end
`ifdef LCD_BUSY_POLL_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      poll <= 1'b0;
      polls <= '0;
      busy <= 1'b0;
      lcd_timeout <= 1'b0;
    end else begin
      poll <= poll_n;
      polls <= polls_n;
      if (state == EHIGH && last && poll) busy <= LCD_data[7];
      if (to_set) lcd_timeout <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// tb_lcd_bus_sequencer: scoreboard bench with an HD44780 bus model for lcd_bus_sequencer.
module tb_lcd_bus_sequencer;
  localparam int T_AS = 2, T_EH = 4, T_AH = 1, T_PWRUP = 10, T_EXEC = 8, T_EXEC_LONG = 20, POLL_MAX = 3;
  localparam int BASE = T_AS + T_EH + T_AH + 2;
`ifdef LCD_BUSY_POLL_EN
  localparam int PCYC = 1 + T_AS + T_EH + T_AH;
  localparam int REC_S = PCYC + 1, REC_L = PCYC + 1;
`else
  localparam int REC_S = T_EXEC, REC_L = T_EXEC_LONG;
`endif
  typedef struct {int lat; bit is_rd; logic [7:0] rd;} exp_t;
  exp_t sb[$];
  logic clk = 1'b0, reset = 1'b1, read = 1'b0, write = 1'b0;
  logic [1:0] address = 2'd0;
  logic [7:0] writedata = 8'h00, readdata, lcd_byte = 8'h00, status;
  logic waitrequest, LCD_E, LCD_RS, LCD_RW, lcd_timeout, e_d = 1'b0;
  wire [7:0] LCD_data;
  int checks = 0, errors = 0, e_pulses = 0, stat_reads = 0, stat_base = -1000;
  bit stuck = 1'b0;
  lcd_bus_sequencer #(.T_AS(T_AS), .T_EH(T_EH), .T_AH(T_AH), .T_PWRUP(T_PWRUP), .T_EXEC(T_EXEC),
    .T_EXEC_LONG(T_EXEC_LONG), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .waitrequest(waitrequest), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_data(LCD_data), .lcd_timeout(lcd_timeout));
  always #5 clk = ~clk;
  // LCD model: busy for the first two status reads after stat_base, or always when stuck
  assign status = {stuck || (stat_reads - stat_base) < 2, 7'h15};
  assign LCD_data = LCD_RW ? (LCD_RS ? lcd_byte : status) : 8'hzz;
  always @(posedge clk) begin
    e_d <= LCD_E;
    if (LCD_E && !e_d) e_pulses <= e_pulses + 1;
    if (!LCD_E && e_d && !LCD_RS && LCD_RW) stat_reads <= stat_reads + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic access(input string tag, input bit wr, input bit both, input logic [1:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd, input int s);
    exp_t e;
    int n = 0, bad = 0, chk_from;
    bit exp_e, in_acc;
    logic [7:0] pd;
    pd = wr ? d : exp_rd;
`ifdef LCD_BUSY_POLL_EN
    chk_from = s;
`else
    chk_from = 0;
`endif
    sb.push_back('{s + BASE, !wr, exp_rd});
    write = wr;
    read = ~wr | both;
    address = a;
    writedata = d;
    #1;
    while (waitrequest && n < 400) begin
      if (n >= chk_from) begin
        exp_e = n >= s + T_AS + 1 && n <= s + T_AS + T_EH;
        in_acc = n > s && n <= s + T_AS + T_EH + T_AH;
        if (LCD_E !== exp_e || LCD_RS !== (in_acc & a[1]) || LCD_RW !== (!in_acc | (a[0] & ~wr)) ||
            (in_acc && LCD_data !== pd)) bad++;
      end
      @(posedge clk);
      #2;
      n++;
    end
    e = sb.pop_front();
    check({tag, " latency"}, n + 1, e.lat);
    if (e.is_rd) check({tag, " readdata"}, readdata, e.rd);
    check({tag, " pin cycles wrong"}, bad, 0);
    @(posedge clk);
    #1;
    read = 1'b0;
    write = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] hold_rd;
    int p0, k;
    repeat (3) @(posedge clk);
    #1;
    check("rst E", LCD_E, 0);
    check("rst RS", LCD_RS, 0);
    check("rst RW", LCD_RW, 1);
    check("rst readdata", readdata, 0);
    check("rst timeout", lcd_timeout, 0);
    check("rst waitrequest", waitrequest, 0);
    reset = 1'b0;
    access("pwrup_wr41", 1, 0, 2'd2, 8'h41, 8'h00, T_PWRUP);
    lcd_byte = 8'h5A;
    access("rd5A", 0, 0, 2'd3, 8'h00, 8'h5A, REC_S);
    lcd_byte = 8'hA5;
    access("rdA5_b2b", 0, 0, 2'd3, 8'h00, 8'hA5, 0);
    access("wr_ins01", 1, 0, 2'd0, 8'h01, 8'h00, 0);
    access("wr_ins38", 1, 0, 2'd0, 8'h38, 8'h00, REC_L);
    access("wr_dat02", 1, 0, 2'd2, 8'h02, 8'h00, REC_S);
    access("wr_ins03", 1, 0, 2'd0, 8'h03, 8'h00, REC_S);
    access("wr_ins04", 1, 0, 2'd0, 8'h04, 8'h00, REC_L);
    access("rd_status", 0, 0, 2'd1, 8'h00, 8'h15, REC_S);
    access("both_wr77", 1, 1, 2'd3, 8'h77, 8'h00, 0);
    lcd_byte = 8'hC3;
    access("rdC3", 0, 0, 2'd3, 8'h00, 8'hC3, REC_S);
    access("wr_dat10", 1, 0, 2'd2, 8'h10, 8'h00, 0);
    check("readdata held after write", readdata, 8'hC3);
    lcd_byte = 8'h3C;
    access("rd3C", 0, 0, 2'd3, 8'h00, 8'h3C, REC_S);
    hold_rd = readdata;
`ifdef LCD_BUSY_POLL_EN
    stat_base = stat_reads;
    p0 = e_pulses;
    access("poll_wr01", 1, 0, 2'd0, 8'h01, 8'h00, 0);
    access("poll_wr20", 1, 0, 2'd2, 8'h20, 8'h00, 3 * PCYC + 1);
    check("poll E pulses", e_pulses - p0, 5);
    check("poll timeout clear", lcd_timeout, 0);
    check("poll keeps readdata", readdata, hold_rd);
    stuck = 1'b1;
    lcd_byte = 8'h66;
    access("rd_after_stuck", 0, 0, 2'd3, 8'h00, 8'h66, 3 * PCYC + 1);
    check("timeout set", lcd_timeout, 1);
    lcd_byte = 8'h67;
    access("rd_sticky", 0, 0, 2'd3, 8'h00, 8'h67, 0);
    check("timeout sticky", lcd_timeout, 1);
    stuck = 1'b0;
`else
    p0 = e_pulses;
    access("fixed_wr01", 1, 0, 2'd0, 8'h01, 8'h00, 0);
    lcd_byte = 8'h44;
    access("fixed_rd44", 0, 0, 2'd3, 8'h00, 8'h44, REC_L);
    check("fixed E pulses", e_pulses - p0, 2);
    check("fixed timeout tied", lcd_timeout, 0);
`endif
    write = 1'b1;
    address = 2'd2;
    writedata = 8'h99;
    k = 0;
    while (!LCD_E && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("E reached before reset", LCD_E, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset E", LCD_E, 0);
    check("midreset RS", LCD_RS, 0);
    check("midreset RW", LCD_RW, 1);
    check("midreset timeout", lcd_timeout, 0);
    check("midreset readdata", readdata, 0);
    check("midreset stall", waitrequest, 1);
    write = 1'b0;
    reset = 1'b0;
    access("pwrup_again", 1, 0, 2'd2, 8'h55, 8'h00, T_PWRUP);
    lcd_byte = 8'hE1;
    access("rdE1", 0, 0, 2'd3, 8'h00, 8'hE1, REC_S);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
